// File: rtl/jt900h_bankregs_if.sv
// Bus bundle for jt900h_bankregs: register read/write ports, bank pointer control
// and the context save/restore streams.
interface jt900h_bankregs_if #(
  parameter int unsigned NBANKS = 4
) ();
  localparam int unsigned BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic          cen;
  logic [7:0]    rd_a_sel;
  logic [1:0]    rd_a_size;
  logic [31:0]   rd_a_data;
  logic [7:0]    rd_b_sel;
  logic [1:0]    rd_b_size;
  logic [31:0]   rd_b_data;
  logic          wr_en;
  logic [7:0]    wr_sel;
  logic [1:0]    wr_size;
  logic [31:0]   wr_data;
  logic [BW-1:0] rfp;
  logic          rfp_inc;
  logic          rfp_dec;
  logic          rfp_ld;
  logic [BW-1:0] rfp_din;
  logic          ctx_start;
  logic          ctx_dir;
  logic [BW-1:0] ctx_bank;
  logic [31:0]   ctx_dout;
  logic          ctx_dvalid;
  logic          ctx_dready;
  logic [31:0]   ctx_din;
  logic          ctx_divalid;
  logic          ctx_diready;
  logic          ctx_busy;
  logic          ctx_done;
  logic          ctx_coll;

  modport master (
    output cen, rd_a_sel, rd_a_size, rd_b_sel, rd_b_size, wr_en, wr_sel, wr_size, wr_data,
    output rfp_inc, rfp_dec, rfp_ld, rfp_din, ctx_start, ctx_dir, ctx_bank, ctx_dready,
    output ctx_din, ctx_divalid,
    input  rd_a_data, rd_b_data, rfp, ctx_dout, ctx_dvalid, ctx_diready, ctx_busy, ctx_done,
    input  ctx_coll
  );

  modport slave (
    input  cen, rd_a_sel, rd_a_size, rd_b_sel, rd_b_size, wr_en, wr_sel, wr_size, wr_data,
    input  rfp_inc, rfp_dec, rfp_ld, rfp_din, ctx_start, ctx_dir, ctx_bank, ctx_dready,
    input  ctx_din, ctx_divalid,
    output rd_a_data, rd_b_data, rfp, ctx_dout, ctx_dvalid, ctx_diready, ctx_busy, ctx_done,
    output ctx_coll
  );
endinterface

// File: rtl/jt900h_bankregs.sv
// Banked register file with pointer registers, bank pointer (RFP) and a context
// engine that streams one bank out to / in from memory for interrupt save/restore.
module jt900h_bankregs #(
  parameter int unsigned NBANKS   = 4,
  parameter int unsigned CTX_REGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  jt900h_bankregs_if.slave bus
);
  localparam int unsigned BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int unsigned NREGS = NBANKS * 4;
  localparam int unsigned AW    = BW + 2;
  localparam logic [1:0]  KLast = 2'(CTX_REGS - 1);

  typedef enum logic [1:0] {StIdle, StSave, StRestore, StDone} state_e;

  logic [31:0]   regs_q [NREGS];
  logic [31:0]   regs_d [NREGS];
  logic [31:0]   ptr_q  [4];
  logic [31:0]   ptr_d  [4];
  state_e        state_q, state_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [1:0]    k_q, k_d;
  logic          coll_q, coll_d;
  logic [BW-1:0] rfp_q, rfp_d;

  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return {lane, 3'b000};
      2'd1:    return {lane[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 32'h0000_00ff;
      2'd1:    return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [31:0] rd_fmt(input logic [31:0] r, input logic [1:0] size,
                                         input logic [1:0] lane);
    return (r >> lane_shift(size, lane)) & size_mask(size);
  endfunction

  // Only the addressed lanes change; the rest of the register is preserved.
  function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] din,
                                           input logic [1:0] size, input logic [1:0] lane);
    logic [4:0]  sh;
    logic [31:0] m;
    sh = lane_shift(size, lane);
    m  = size_mask(size) << sh;
    return (old & ~m) | ((din << sh) & m);
  endfunction

  logic [31:0]   rd_a_raw, rd_b_raw;
  logic [AW-1:0] wr_idx, ctx_idx;
  logic [BW-1:0] wr_bank;
  logic          wr_drop;

  assign rd_a_raw = bus.rd_a_sel[7] ? ptr_q[bus.rd_a_sel[3:2]]
                                    : regs_q[{bus.rd_a_sel[4 +: BW], bus.rd_a_sel[3:2]}];
  assign rd_b_raw = bus.rd_b_sel[7] ? ptr_q[bus.rd_b_sel[3:2]]
                                    : regs_q[{bus.rd_b_sel[4 +: BW], bus.rd_b_sel[3:2]}];
  assign bus.rd_a_data = rd_fmt(rd_a_raw, bus.rd_a_size, bus.rd_a_sel[1:0]);
  assign bus.rd_b_data = rd_fmt(rd_b_raw, bus.rd_b_size, bus.rd_b_sel[1:0]);

  assign wr_bank = bus.wr_sel[4 +: BW];
  assign wr_idx  = {wr_bank, bus.wr_sel[3:2]};
  assign ctx_idx = {bank_q, k_q};
  // The restore stream owns the latched bank; external writes into it are dropped.
  assign wr_drop = bus.wr_en && !bus.wr_sel[7] && (state_q == StRestore) && (wr_bank == bank_q);

  always_comb begin
    regs_d  = regs_q;
    ptr_d   = ptr_q;
    state_d = state_q;
    bank_d  = bank_q;
    k_d     = k_q;
    coll_d  = wr_drop;
    rfp_d   = rfp_q;

    if (bus.wr_en && !wr_drop) begin
      if (bus.wr_sel[7]) begin
        ptr_d[bus.wr_sel[3:2]] = wr_merge(ptr_q[bus.wr_sel[3:2]], bus.wr_data, bus.wr_size,
                                          bus.wr_sel[1:0]);
      end else begin
        regs_d[wr_idx] = wr_merge(regs_q[wr_idx], bus.wr_data, bus.wr_size, bus.wr_sel[1:0]);
      end
    end

    if (bus.rfp_ld) begin
      rfp_d = bus.rfp_din;
    end else if (bus.rfp_inc && !bus.rfp_dec) begin
      rfp_d = rfp_q + BW'(1);
    end else if (bus.rfp_dec && !bus.rfp_inc) begin
      rfp_d = rfp_q - BW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.ctx_start) begin
          bank_d  = bus.ctx_bank;
          k_d     = 2'd0;
          state_d = bus.ctx_dir ? StRestore : StSave;
        end
      end
      StSave: begin
        if (bus.ctx_dready) begin
          k_d = k_q + 2'd1;
          if (k_q == KLast) state_d = StDone;
        end
      end
      StRestore: begin
        if (bus.ctx_divalid) begin
          regs_d[ctx_idx] = bus.ctx_din;
          k_d             = k_q + 2'd1;
          if (k_q == KLast) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q  <= '{default: '0};
      ptr_q   <= '{default: '0};
      state_q <= StIdle;
      bank_q  <= '0;
      k_q     <= '0;
      coll_q  <= 1'b0;
      rfp_q   <= '0;
    end else if (bus.cen) begin
      regs_q  <= regs_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
      bank_q  <= bank_d;
      k_q     <= k_d;
      coll_q  <= coll_d;
      rfp_q   <= rfp_d;
    end
  end

  assign bus.rfp         = rfp_q;
  assign bus.ctx_dvalid  = (state_q == StSave);
  assign bus.ctx_dout    = (state_q == StSave) ? regs_q[ctx_idx] : 32'd0;
  assign bus.ctx_diready = (state_q == StRestore);
  assign bus.ctx_busy    = (state_q != StIdle);
  assign bus.ctx_done    = (state_q == StDone);
  assign bus.ctx_coll    = coll_q;

  // Bank-field bits above BW are don't-care.
  logic unused_sel;
  assign unused_sel = ^{bus.rd_a_sel[6:4], bus.rd_b_sel[6:4], bus.wr_sel[6:4]};
endmodule

// File: tb/tb_jt900h_bankregs.sv
// Directed bench for jt900h_bankregs: lane access, RFP update, context save/restore,
// collision, clock enable and mid-transfer reset.
module tb_jt900h_bankregs;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   words;

  jt900h_bankregs_if #(.NBANKS(4)) bus ();

  jt900h_bankregs #(.NBANKS(4), .CTX_REGS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] sel, input logic [1:0] size, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_size = size;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd_long(input logic [7:0] sel, input string tag, input logic [31:0] exp);
    bus.rd_a_sel  = sel;
    bus.rd_a_size = 2'd2;
    #1;
    chk(tag, bus.rd_a_data, exp);
  endtask

  logic       rdy_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] dout_exp [6] = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA3, 32'hA3};
  logic [31:0] rw [4] = '{32'h1020_3040, 32'h5566_7788, 32'h9ABC_DEF0, 32'h0F0F_0F0F};

  initial begin
    bus.cen = 1'b1;
    bus.rd_a_sel = 8'h18; bus.rd_a_size = 2'd2;
    bus.rd_b_sel = 8'h00; bus.rd_b_size = 2'd2;
    bus.wr_en = 1'b0; bus.wr_sel = 8'h00; bus.wr_size = 2'd0; bus.wr_data = 32'd0;
    bus.rfp_inc = 1'b0; bus.rfp_dec = 1'b0; bus.rfp_ld = 1'b0; bus.rfp_din = 2'd0;
    bus.ctx_start = 1'b0; bus.ctx_dir = 1'b0; bus.ctx_bank = 2'd0; bus.ctx_dready = 1'b0;
    bus.ctx_din = 32'd0; bus.ctx_divalid = 1'b0;
    tick(); tick();
    chk("reset_rfp", 32'(bus.rfp), 32'd0);
    chk("reset_busy", 32'(bus.ctx_busy), 32'd0);
    chk("reset_dvalid", 32'(bus.ctx_dvalid), 32'd0);
    chk("reset_reg", bus.rd_a_data, 32'd0);
    rst = 1'b1;
    tick();

    // Lane access
    wr(8'h18, 2'd2, 32'h1122_3344);
    bus.rd_a_sel = 8'h19; bus.rd_a_size = 2'd0;
    bus.rd_b_sel = 8'h1A; bus.rd_b_size = 2'd1;
    #1;
    chk("rd_byte_lane1", bus.rd_a_data, 32'h0000_0033);
    chk("rd_word_lane2", bus.rd_b_data, 32'h0000_1122);
    bus.rd_a_sel = 8'h18; bus.rd_a_size = 2'd2;
    bus.wr_en = 1'b1; bus.wr_sel = 8'h18; bus.wr_size = 2'd0; bus.wr_data = 32'h0000_00EE;
    #1;
    chk("rd_old_same_cycle", bus.rd_a_data, 32'h1122_3344);
    tick();
    bus.wr_en = 1'b0;
    chk("rd_new_next_cycle", bus.rd_a_data, 32'h1122_33EE);
    rd_long(8'h58, "bank_hi_bits_ignored", 32'h1122_33EE);
    wr(8'h1B, 2'd0, 32'h0000_00AB);
    rd_long(8'h18, "byte_lane3_write", 32'hAB22_33EE);
    bus.rd_b_sel = 8'h1B; bus.rd_b_size = 2'd1;
    #1;
    chk("word_ignores_bit0", bus.rd_b_data, 32'h0000_AB22);

    // RFP
    bus.rfp_ld = 1'b1; bus.rfp_din = 2'd3; tick(); bus.rfp_ld = 1'b0;
    chk("rfp_ld3", 32'(bus.rfp), 32'd3);
    bus.rfp_inc = 1'b1; tick();
    chk("rfp_inc_wrap", 32'(bus.rfp), 32'd0);
    bus.rfp_dec = 1'b1; tick();
    chk("rfp_inc_dec", 32'(bus.rfp), 32'd0);
    bus.rfp_inc = 1'b0; tick(); bus.rfp_dec = 1'b0;
    chk("rfp_dec_wrap", 32'(bus.rfp), 32'd3);
    bus.rfp_ld = 1'b1; bus.rfp_din = 2'd2; bus.rfp_inc = 1'b1; tick();
    bus.rfp_ld = 1'b0; bus.rfp_inc = 1'b0;
    chk("rfp_ld_priority", 32'(bus.rfp), 32'd2);

    // Save bank 2, with an ignored ctx_start mid-transfer
    wr(8'h20, 2'd2, 32'hA0); wr(8'h24, 2'd2, 32'hA1);
    wr(8'h28, 2'd2, 32'hA2); wr(8'h2C, 2'd2, 32'hA3);
    bus.ctx_start = 1'b1; bus.ctx_dir = 1'b0; bus.ctx_bank = 2'd2;
    tick();
    bus.ctx_start = 1'b0;
    chk("save_busy", 32'(bus.ctx_busy), 32'd1);
    words = 0;
    for (int i = 0; i < 6; i++) begin
      bus.ctx_dready = rdy_pat[i];
      bus.ctx_start  = (i == 2);
      bus.ctx_dir    = 1'b1;
      bus.ctx_bank   = 2'd0;
      #1;
      chk($sformatf("save_dvalid_%0d", i), 32'(bus.ctx_dvalid), 32'd1);
      chk($sformatf("save_dout_%0d", i), bus.ctx_dout, dout_exp[i]);
      if (bus.ctx_dvalid && bus.ctx_dready) words++;
      tick();
    end
    bus.ctx_dready = 1'b0; bus.ctx_start = 1'b0;
    chk("save_words", 32'(words), 32'd4);
    chk("save_done", 32'(bus.ctx_done), 32'd1);
    chk("save_dvalid_off", 32'(bus.ctx_dvalid), 32'd0);
    tick();
    chk("save_done_pulse", 32'(bus.ctx_done), 32'd0);
    chk("save_busy_off", 32'(bus.ctx_busy), 32'd0);
    chk("save_not_restarted", 32'(bus.ctx_diready), 32'd0);

    // Restore bank 0 with gaps, a collision and a pointer write
    bus.ctx_start = 1'b1; bus.ctx_dir = 1'b1; bus.ctx_bank = 2'd0;
    tick();
    bus.ctx_start = 1'b0;
    chk("rest_diready", 32'(bus.ctx_diready), 32'd1);
    bus.ctx_divalid = 1'b1; bus.ctx_din = rw[0]; tick();
    bus.ctx_din = rw[1]; tick();
    bus.ctx_divalid = 1'b0;
    bus.rfp_inc = 1'b1;
    wr(8'h04, 2'd2, 32'hDEAD_BEEF);
    bus.rfp_inc = 1'b0;
    chk("rest_coll", 32'(bus.ctx_coll), 32'd1);
    wr(8'h8C, 2'd2, 32'hCAFE_F00D);
    chk("rest_coll_pulse", 32'(bus.ctx_coll), 32'd0);
    chk("rest_rfp_moved", 32'(bus.rfp), 32'd3);
    bus.ctx_divalid = 1'b1; bus.ctx_din = rw[2]; tick();
    bus.ctx_din = rw[3]; tick();
    bus.ctx_divalid = 1'b0;
    chk("rest_done", 32'(bus.ctx_done), 32'd1);
    chk("rest_diready_off", 32'(bus.ctx_diready), 32'd0);
    tick();
    chk("rest_busy_off", 32'(bus.ctx_busy), 32'd0);
    rd_long(8'h00, "rest_reg0", rw[0]);
    rd_long(8'h04, "rest_reg1_dropped_wr", rw[1]);
    rd_long(8'h08, "rest_reg2", rw[2]);
    rd_long(8'h0C, "rest_reg3", rw[3]);
    rd_long(8'h8C, "xsp_write", 32'hCAFE_F00D);

    // Clock enable freeze, then reset in SAVE at k=2
    bus.ctx_start = 1'b1; bus.ctx_dir = 1'b0; bus.ctx_bank = 2'd2;
    tick();
    bus.ctx_start = 1'b0;
    bus.cen = 1'b0; bus.ctx_dready = 1'b1;
    tick(); tick();
    chk("cen_hold_dvalid", 32'(bus.ctx_dvalid), 32'd1);
    chk("cen_hold_dout", bus.ctx_dout, 32'hA0);
    bus.cen = 1'b1;
    tick(); tick();
    bus.ctx_dready = 1'b0;
    chk("save_k2_dout", bus.ctx_dout, 32'hA2);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.ctx_busy), 32'd0);
    chk("rst_dvalid", 32'(bus.ctx_dvalid), 32'd0);
    rd_long(8'h20, "rst_bank2_reg0", 32'd0);
    rd_long(8'h8C, "rst_xsp", 32'd0);
    chk("rst_rfp", 32'(bus.rfp), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_no_done", 32'(bus.ctx_done), 32'd0);
    chk("rst_idle", 32'(bus.ctx_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt900h_bankregs.md
Name: jt900h_bankregs

Overview:
Parametrised successor of the CPU register file. Holds NBANKS general-purpose register banks plus four 32-bit pointer registers (XIX, XIY, XIZ, XSP), with byte/word/long access at any lane. Adds a bank pointer (RFP) with increment/decrement/load, and a context engine. The engine streams one bank out to memory or in from memory over valid/ready handshakes, so the microcode can save and restore it on interrupt entry and RETI. Sits between the ucode control unit, the ALU result bus and the memory controller.

Parameters:
NBANKS, 4, number of register banks; power of two, 2..8; BW=$clog2(NBANKS)
CTX_REGS, 4, registers moved per context transfer, 1..4, starting at index 0 (XWA, XBC, XDE, XHL)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
cen  input  1  clock enable; when low all state holds
rd_a_sel  input  8  read port A address: [7]=1 pointer reg [3:2]; [7]=0 bank [6:4] (low BW bits), reg [3:2]; [1:0] byte lane
rd_a_size  input  2  0 byte, 1 word, 2/3 long
rd_a_data  output  32  port A data, zero-extended
rd_b_sel  input  8  read port B address, same coding
rd_b_size  input  2  as rd_a_size
rd_b_data  output  32  port B data
wr_en  input  1  write strobe
wr_sel  input  8  write address, same coding
wr_size  input  2  write size
wr_data  input  32  write data, LSB-aligned
rfp  output  BW  current bank pointer
rfp_inc  input  1  INCF
rfp_dec  input  1  DECF
rfp_ld  input  1  LDF
rfp_din  input  BW  LDF value
ctx_start  input  1  start a context transfer
ctx_dir  input  1  0 save (registers to stream), 1 restore (stream to registers)
ctx_bank  input  BW  bank to transfer
ctx_dout  output  32  save-stream data
ctx_dvalid  output  1  save-stream valid
ctx_dready  input  1  save-stream ready
ctx_din  input  32  restore-stream data
ctx_divalid  input  1  restore-stream valid
ctx_diready  output  1  restore-stream ready
ctx_busy  output  1  transfer in progress
ctx_done  output  1  one-cycle pulse after last word
ctx_coll  output  1  one-cycle pulse: external write dropped

Behaviour:
- Reset (rst=0, async): all registers 0, rfp=0, state IDLE, ctx_* outputs 0. Reset mid-transfer aborts it; no done pulse.
- Bank-field bits of sel above BW are ignored. Lane handling:
  - Word access ignores sel[0]; long access ignores sel[1:0].
  - Byte lanes wrap inside the 32-bit register only.
- Reads are combinational from storage: data = reg >> (lane*8), masked to size. A read in the same cycle as a write to the same register returns the old value; the new value is visible next cycle.
- Writes take effect at the clk edge with cen=1 and touch only the addressed lanes.
- RFP update, in priority order:
  - rfp_ld sets rfp to rfp_din.
  - Otherwise inc and dec together leave rfp unchanged.
  - Otherwise inc or dec adds or subtracts 1 modulo NBANKS (wraps 3->0 and 0->3 at NBANKS=4).
- FSM states: IDLE, SAVE, RESTORE, DONE.
- IDLE:
  - ctx_start latches ctx_bank and ctx_dir, clears index k=0, and moves to SAVE or RESTORE.
  - ctx_start while not IDLE is ignored.
- SAVE:
  - ctx_dvalid=1 and ctx_dout is the long register k of the latched bank, sampled live each cycle.
  - dvalid and dout stay stable until ready, except where an external write changes the register.
  - On dvalid&dready, k increments. After register CTX_REGS-1 is accepted, go to DONE.
- RESTORE:
  - ctx_diready=1.
  - On divalid&diready, ctx_din is written as a long to register k, then k increments. After the last register, go to DONE.
- DONE: ctx_done=1 for one cycle, then IDLE.
- ctx_busy=1 in SAVE, RESTORE and DONE.
- Collision: in RESTORE, a wr_en to any register of the latched bank is dropped and ctx_coll pulses the next cycle. Writes to other banks and to pointer registers proceed normally.
- Changing rfp during a transfer is allowed and does not affect the latched bank.
- cen=0 freezes the FSM and all handshake outputs. Handshake transfers are counted only when cen=1.

Test Plan:
- Write long 0x11223344 to bank1 reg2 (sel=0x18), then read sel=0x19 size byte -> 0x00000033; read size word at sel=0x1A -> 0x00001122.
- rfp=3, pulse rfp_inc -> rfp=0; then rfp_inc+rfp_dec together -> 0; then rfp_ld with din=2 and rfp_inc -> 2.
- Save bank 2 holding 0xA0..A3 with ctx_dready toggling 1,0,1,1,0,1 -> ctx_dout sequence 0xA0,A1,A2,A3, each held while ready=0; ctx_done pulses once, ctx_busy drops the cycle after.
- Restore bank 0 with divalid gaps, wr_en to bank0 reg1 mid-transfer -> write dropped, ctx_coll pulses, final regs equal stream words; concurrent write to XSP (sel=0x8C) succeeds.
- Assert rst during a SAVE at k=2 -> ctx_busy=0, dvalid=0, all registers 0, no ctx_done.
- ctx_start during SAVE -> ignored; exactly CTX_REGS words emitted.
